iq_sweep_sequencer: RTL and testbench

Frequency-sweep controller for the IQ function generator block. It drives the generator's `on` and `shift_phase` inputs through a programmed list of equally spaced frequencies. At each point it waits a settle time, opens an acquisition window for the downstream IQ demodulator/averager, and then hands the point off through a valid/ack handshake. It sits between the register bank and the IQ fgen/demod datapath and replaces software-stepped sweeps.

---
 rtl/iq_sweep_sequencer_if.sv | 41 ++++
 rtl/iq_sweep_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_iq_sweep_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iq_sweep_sequencer_if.sv
// Bundles the sweep configuration, control and fgen/demod outputs of the sweep sequencer.
// Latency: none. This is wiring only.
// Backpressure: ack_i is the consumer's accept for point_valid_o.
interface iq_sweep_sequencer_if #(
    parameter int PHASEBITS = 32,
    parameter int CNTBITS   = 32,
    parameter int PTSBITS   = 16
);
    logic                 start_i;
    logic                 abort_i;
    logic                 continuous_i;
    logic [PHASEBITS-1:0] freq_start_i;
    logic [PHASEBITS-1:0] freq_step_i;
    logic [PTSBITS-1:0]   npoints_i;
    logic [CNTBITS-1:0]   settle_i;
    logic [CNTBITS-1:0]   acq_i;
    logic                 ack_i;
    logic                 on_o;
    logic [PHASEBITS-1:0] shift_phase_o;
    logic                 acq_en_o;
    logic                 point_valid_o;
    logic [PTSBITS-1:0]   point_idx_o;
    logic                 busy_o;
    logic                 done_o;

    // Register bank / consumer side.
    modport master (
        output start_i, abort_i, continuous_i, freq_start_i, freq_step_i,
               npoints_i, settle_i, acq_i, ack_i,
        input  on_o, shift_phase_o, acq_en_o, point_valid_o, point_idx_o,
               busy_o, done_o
    );

    // Sequencer side.
    modport slave (
        input  start_i, abort_i, continuous_i, freq_start_i, freq_step_i,
               npoints_i, settle_i, acq_i, ack_i,
        output on_o, shift_phase_o, acq_en_o, point_valid_o, point_idx_o,
               busy_o, done_o
    );
endinterface

// File: rtl/iq_sweep_sequencer.sv
// Steps the IQ fgen through equally spaced frequencies: settle, acquire, hand off per point.
// Latency: all outputs registered; start seen at an edge drives on_o/shift_phase_o from that edge.
// Backpressure: holds point_valid_o in WAIT_ACK until ack_i; with ack tied high a point takes S+A+1 cycles.
module iq_sweep_sequencer #(
    parameter int PHASEBITS = 32,
    parameter int CNTBITS   = 32,
    parameter int PTSBITS   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    iq_sweep_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_ACQ,
        S_WAIT_ACK
    } state_t;

    state_t               state_q, state_d;
    logic [CNTBITS-1:0]   cnt_q, cnt_d;
    logic [PHASEBITS-1:0] phase_q, phase_d;
    logic [PHASEBITS-1:0] fstart_q, fstart_d;
    logic [PHASEBITS-1:0] fstep_q, fstep_d;
    logic [PTSBITS-1:0]   last_q, last_d;
    logic [CNTBITS-1:0]   settle_q, settle_d;
    logic [CNTBITS-1:0]   acq_q, acq_d;
    logic [PTSBITS-1:0]   idx_q, idx_d;
    logic                 on_q, on_d;
    logic                 acq_en_q, acq_en_d;
    logic                 pv_q, pv_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    // Point entry uses the live inputs on the start cycle, the latched copies afterwards.
    logic                 enter_point;
    logic [CNTBITS-1:0]   settle_src;
    logic [CNTBITS-1:0]   acq_src;

    assign bus.on_o          = on_q;
    assign bus.shift_phase_o = phase_q;
    assign bus.acq_en_o      = acq_en_q;
    assign bus.point_valid_o = pv_q;
    assign bus.point_idx_o   = idx_q;
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;

    // Next-state and next-output logic; abort overrides everything else.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        fstart_d    = fstart_q;
        fstep_d     = fstep_q;
        last_d      = last_q;
        settle_d    = settle_q;
        acq_d       = acq_q;
        idx_d       = idx_q;
        on_d        = on_q;
        acq_en_d    = acq_en_q;
        pv_d        = pv_q;
        done_d      = 1'b0;
        enter_point = 1'b0;

        if (state_q == S_IDLE) begin
            settle_src = bus.settle_i;
            acq_src    = (bus.acq_i == '0) ? CNTBITS'(1) : bus.acq_i;
        end else begin
            settle_src = settle_q;
            acq_src    = acq_q;
        end

        if (bus.abort_i) begin
            state_d  = S_IDLE;
            on_d     = 1'b0;
            acq_en_d = 1'b0;
            pv_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        fstart_d    = bus.freq_start_i;
                        fstep_d     = bus.freq_step_i;
                        last_d      = (bus.npoints_i == '0) ? '0 : bus.npoints_i - PTSBITS'(1);
                        settle_d    = settle_src;
                        acq_d       = acq_src;
                        phase_d     = bus.freq_start_i;
                        idx_d       = '0;
                        on_d        = 1'b1;
                        enter_point = 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d  = S_ACQ;
                        cnt_d    = acq_q - CNTBITS'(1);
                        acq_en_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNTBITS'(1);
                    end
                end
                S_ACQ: begin
                    if (cnt_q == '0) begin
                        state_d  = S_WAIT_ACK;
                        acq_en_d = 1'b0;
                        pv_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNTBITS'(1);
                    end
                end
                S_WAIT_ACK: begin
                    if (bus.ack_i) begin
                        pv_d = 1'b0;
                        if (idx_q != last_q) begin
                            idx_d       = idx_q + PTSBITS'(1);
                            phase_d     = phase_q + fstep_q;
                            enter_point = 1'b1;
                        end else if (bus.continuous_i) begin
                            idx_d       = '0;
                            phase_d     = fstart_q;
                            enter_point = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            on_d    = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A new point skips SETTLE entirely when no settle time is programmed.
        if (enter_point) begin
            if (settle_src != '0) begin
                state_d  = S_SETTLE;
                cnt_d    = settle_src - CNTBITS'(1);
                acq_en_d = 1'b0;
            end else begin
                state_d  = S_ACQ;
                cnt_d    = acq_src - CNTBITS'(1);
                acq_en_d = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            phase_q  <= '0;
            fstart_q <= '0;
            fstep_q  <= '0;
            last_q   <= '0;
            settle_q <= '0;
            acq_q    <= '0;
            idx_q    <= '0;
            on_q     <= 1'b0;
            acq_en_q <= 1'b0;
            pv_q     <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            fstart_q <= fstart_d;
            fstep_q  <= fstep_d;
            last_q   <= last_d;
            settle_q <= settle_d;
            acq_q    <= acq_d;
            idx_q    <= idx_d;
            on_q     <= on_d;
            acq_en_q <= acq_en_d;
            pv_q     <= pv_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: tb/tb_iq_sweep_sequencer.sv
// Directed bench for the sweep sequencer; edge counts are relative to the edge that samples start.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: ack is driven per scenario (tied high, stalled, or pulsed).
module tb_iq_sweep_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    iq_sweep_sequencer_if #(.PHASEBITS(32), .CNTBITS(32), .PTSBITS(16)) sif ();

    iq_sweep_sequencer #(.PHASEBITS(32), .CNTBITS(32), .PTSBITS(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (sif.slave)
    );

    // {on, acq_en, point_valid, done, busy}
    wire [4:0] flags = {sif.on_o, sif.acq_en_o, sif.point_valid_o, sif.done_o, sif.busy_o};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [31:0] fs, input logic [31:0] fst, input logic [15:0] n,
                       input logic [31:0] s, input logic [31:0] a);
        sif.freq_start_i = fs;
        sif.freq_step_i  = fst;
        sif.npoints_i    = n;
        sif.settle_i     = s;
        sif.acq_i        = a;
    endtask

    // Leaves the bench just after the edge that sampled start (edge 1).
    task automatic go();
        sif.start_i = 1'b1;
        tick();
        sif.start_i = 1'b0;
    endtask

    task automatic to_idle();
        sif.start_i      = 1'b0;
        sif.continuous_i = 1'b0;
        sif.ack_i        = 1'b0;
        sif.abort_i      = 1'b1;
        tick();
        sif.abort_i      = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sif.start_i = 1'b0; sif.abort_i = 1'b0; sif.continuous_i = 1'b0; sif.ack_i = 1'b0;
        cfg(0, 0, 0, 0, 0);
        tick(); tick();
        total++;
        if ({flags, sif.shift_phase_o, sif.point_idx_o} !== {5'b0, 32'h0, 16'h0}) begin
            bad++;
            $display("FAIL reset: flags=%b phase=%h idx=%0d required all zero", flags, sif.shift_phase_o, sif.point_idx_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [4:0]  ef;
        logic [31:0] ep;
        logic [15:0] ei;
        cfg(1000, 500, 3, 2, 4);
        sif.ack_i = 1'b1;
        go();
        for (int c = 1; c <= 24; c++) begin
            ef[4] = (c < 22);
            ef[3] = (c >= 3 && c <= 6) || (c >= 10 && c <= 13) || (c >= 17 && c <= 20);
            ef[2] = (c == 7) || (c == 14) || (c == 21);
            ef[1] = (c == 22);
            ef[0] = (c < 22);
            ep = (c < 8) ? 32'd1000 : (c < 15) ? 32'd1500 : 32'd2000;
            ei = (c < 8) ? 16'd0 : (c < 15) ? 16'd1 : 16'd2;
            total++;
            if ({flags, sif.shift_phase_o, sif.point_idx_o} !== {ef, ep, ei}) begin
                bad++;
                $display("FAIL basic edge %0d: flags=%b phase=%0d idx=%0d required flags=%b phase=%0d idx=%0d",
                         c, flags, sif.shift_phase_o, sif.point_idx_o, ef, ep, ei);
            end
            tick();
        end
        sif.ack_i = 1'b0;
    endtask

    task automatic test_down_wrap();
        logic [4:0]  ef;
        logic [31:0] ep;
        cfg(1, 32'hFFFF_FFFF, 3, 0, 1);
        sif.ack_i = 1'b1;
        go();
        for (int c = 1; c <= 8; c++) begin
            ef[4] = (c < 7);
            ef[3] = (c == 1) || (c == 3) || (c == 5);
            ef[2] = (c == 2) || (c == 4) || (c == 6);
            ef[1] = (c == 7);
            ef[0] = (c < 7);
            ep = (c < 3) ? 32'h1 : (c < 5) ? 32'h0 : 32'hFFFF_FFFF;
            total++;
            if ({flags, sif.shift_phase_o} !== {ef, ep}) begin
                bad++;
                $display("FAIL down_wrap edge %0d: flags=%b phase=%h required flags=%b phase=%h",
                         c, flags, sif.shift_phase_o, ef, ep);
            end
            tick();
        end
        sif.ack_i = 1'b0;
    endtask

    task automatic test_stalled_ack();
        logic seen;
        cfg(200, 20, 2, 1, 2);
        sif.ack_i = 1'b0;
        go();
        tick(); tick(); tick();
        for (int k = 0; k <= 10; k++) begin
            total++;
            if ({sif.point_valid_o, sif.acq_en_o, sif.on_o, sif.point_idx_o, sif.shift_phase_o} !==
                {1'b1, 1'b0, 1'b1, 16'd0, 32'd200}) begin
                bad++;
                $display("FAIL stall hold %0d: pv=%b acq=%b on=%b idx=%0d phase=%0d required pv=1 acq=0 on=1 idx=0 phase=200",
                         k, sif.point_valid_o, sif.acq_en_o, sif.on_o, sif.point_idx_o, sif.shift_phase_o);
            end
            if (k < 10) tick();
        end
        sif.ack_i = 1'b1;
        tick();
        total++;
        if ({sif.point_valid_o, sif.point_idx_o, sif.shift_phase_o, sif.on_o} !== {1'b0, 16'd1, 32'd220, 1'b1}) begin
            bad++;
            $display("FAIL stall advance: pv=%b idx=%0d phase=%0d on=%b required pv=0 idx=1 phase=220 on=1",
                     sif.point_valid_o, sif.point_idx_o, sif.shift_phase_o, sif.on_o);
        end
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            seen = sif.done_o;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL stall done: done_o never seen within 20 cycles, required one pulse");
        end
        sif.ack_i = 1'b0;
    endtask

    task automatic test_continuous_abort();
        logic [15:0] ei;
        logic [31:0] ep;
        logic        done_seen;
        cfg(10, 5, 2, 0, 2);
        sif.continuous_i = 1'b1;
        sif.ack_i = 1'b1;
        done_seen = 1'b0;
        go();
        for (int c = 1; c <= 10; c++) begin
            done_seen = done_seen | sif.done_o;
            total++;
            if ({sif.on_o, sif.busy_o} !== 2'b11) begin
                bad++;
                $display("FAIL cont on edge %0d: on=%b busy=%b required on=1 busy=1", c, sif.on_o, sif.busy_o);
            end
            if (c == 1 || c == 4 || c == 7 || c == 10) begin
                ei = (c == 1 || c == 7) ? 16'd0 : 16'd1;
                ep = (c == 1 || c == 7) ? 32'd10 : 32'd15;
                total++;
                if ({sif.acq_en_o, sif.point_idx_o, sif.shift_phase_o} !== {1'b1, ei, ep}) begin
                    bad++;
                    $display("FAIL cont point edge %0d: acq=%b idx=%0d phase=%0d required acq=1 idx=%0d phase=%0d",
                             c, sif.acq_en_o, sif.point_idx_o, sif.shift_phase_o, ei, ep);
                end
            end
            if (c < 10) tick();
        end
        sif.abort_i = 1'b1;
        tick();
        sif.abort_i = 1'b0;
        done_seen = done_seen | sif.done_o;
        total++;
        if ({sif.on_o, sif.acq_en_o, sif.point_valid_o, sif.busy_o} !== 4'b0000) begin
            bad++;
            $display("FAIL abort: on=%b acq=%b pv=%b busy=%b required all 0",
                     sif.on_o, sif.acq_en_o, sif.point_valid_o, sif.busy_o);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            done_seen = done_seen | sif.done_o | sif.busy_o;
        end
        total++;
        if (done_seen !== 1'b0) begin
            bad++;
            $display("FAIL cont no_done: done/busy seen=%b required 0", done_seen);
        end
        sif.continuous_i = 1'b0;
        sif.ack_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        cfg(7, 1, 2, 5, 3);
        go();
        tick();
        rst = 1'b1;
        tick();
        total++;
        if ({flags, sif.shift_phase_o, sif.point_idx_o} !== {5'b0, 32'h0, 16'h0}) begin
            bad++;
            $display("FAIL reset_mid: flags=%b phase=%h idx=%0d required all zero", flags, sif.shift_phase_o, sif.point_idx_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_start_busy();
        cfg(100, 10, 1, 3, 2);
        sif.ack_i = 1'b1;
        go();
        tick();
        sif.freq_start_i = 999;
        sif.start_i = 1'b1;
        tick();
        sif.start_i = 1'b0;
        total++;
        if ({sif.shift_phase_o, sif.on_o, sif.busy_o} !== {32'd100, 2'b11}) begin
            bad++;
            $display("FAIL start_busy ignore: phase=%0d on=%b busy=%b required phase=100 on=1 busy=1",
                     sif.shift_phase_o, sif.on_o, sif.busy_o);
        end
        tick(); tick(); tick();
        total++;
        if (flags !== 5'b10101) begin
            bad++;
            $display("FAIL start_busy wait: flags=%b required 10101", flags);
        end
        tick();
        total++;
        if ({flags, sif.shift_phase_o} !== {5'b00010, 32'd100}) begin
            bad++;
            $display("FAIL start_busy done: flags=%b phase=%0d required flags=00010 phase=100", flags, sif.shift_phase_o);
        end
        tick();
        total++;
        if (flags !== 5'b00000) begin
            bad++;
            $display("FAIL start_busy after: flags=%b required 00000", flags);
        end
        sif.ack_i = 1'b0;
    endtask

    task automatic test_start_abort();
        cfg(55, 1, 2, 0, 1);
        sif.start_i = 1'b1;
        sif.abort_i = 1'b1;
        tick();
        sif.start_i = 1'b0;
        sif.abort_i = 1'b0;
        total++;
        if (flags !== 5'b00000) begin
            bad++;
            $display("FAIL start_abort: flags=%b required 00000", flags);
        end
        tick();
        total++;
        if (flags !== 5'b00000) begin
            bad++;
            $display("FAIL start_abort after: flags=%b required 00000", flags);
        end
    endtask

    task automatic test_degenerate();
        cfg(42, 3, 0, 0, 0);
        sif.ack_i = 1'b0;
        go();
        total++;
        if ({flags, sif.shift_phase_o, sif.point_idx_o} !== {5'b11001, 32'd42, 16'd0}) begin
            bad++;
            $display("FAIL degen acq: flags=%b phase=%0d idx=%0d required flags=11001 phase=42 idx=0",
                     flags, sif.shift_phase_o, sif.point_idx_o);
        end
        tick();
        total++;
        if (flags !== 5'b10101) begin
            bad++;
            $display("FAIL degen wait1: flags=%b required 10101", flags);
        end
        tick();
        total++;
        if (flags !== 5'b10101) begin
            bad++;
            $display("FAIL degen wait2: flags=%b required 10101", flags);
        end
        sif.ack_i = 1'b1;
        tick();
        total++;
        if (flags !== 5'b00010) begin
            bad++;
            $display("FAIL degen done: flags=%b required 00010", flags);
        end
        tick();
        total++;
        if (flags !== 5'b00000) begin
            bad++;
            $display("FAIL degen after: flags=%b required 00000", flags);
        end
        sif.ack_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        to_idle();
        test_down_wrap();
        to_idle();
        test_stalled_ack();
        to_idle();
        test_continuous_abort();
        to_idle();
        test_reset_mid();
        to_idle();
        test_start_busy();
        to_idle();
        test_start_abort();
        to_idle();
        test_degenerate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
